// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: owns the PC, runs a one-outstanding fetch against a
// variable-latency instruction memory and registers {instruction, PC+4, valid} for IF/ID.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        br_taken,
  input  logic [31:0] br_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] instruction,
  output logic [31:0] PC,
  output logic        inst_valid
);

  typedef enum logic [1:0] {StFetch, StWait, StHold, StDiscard} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] buf_q;
  logic [31:0] buf_pc_q;  // PC+4 of the buffered word
  logic [31:0] pc_plus4;

  assign pc_plus4  = pc_q + 32'd4;
  assign imem_req  = (state_q == StFetch) & ~br_taken & rst;
  assign imem_addr = pc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StFetch;
      pc_q        <= RESET_PC;
      buf_q       <= 32'h0;
      buf_pc_q    <= 32'h0;
      instruction <= NOP_INST;
      PC          <= 32'h0;
      inst_valid  <= 1'b0;
    end else if (br_taken) begin
      // Redirect wins over freeze and any response landing this cycle.
      instruction <= NOP_INST;
      inst_valid  <= 1'b0;
      pc_q        <= br_addr;
      unique case (state_q)
        StWait, StDiscard: state_q <= imem_valid ? StFetch : StDiscard;
        StFetch, StHold:   state_q <= StFetch;
      endcase
    end else begin
      // Bubble by default; overridden below when a word is delivered.
      if (!freeze) begin
        instruction <= NOP_INST;
        inst_valid  <= 1'b0;
      end
      unique case (state_q)
        StFetch: state_q <= StWait;
        StWait: begin
          if (imem_valid) begin
            pc_q <= pc_plus4;
            if (freeze) begin
              buf_q    <= imem_rdata;
              buf_pc_q <= pc_plus4;
              state_q  <= StHold;
            end else begin
              instruction <= imem_rdata;
              PC          <= pc_plus4;
              inst_valid  <= 1'b1;
              state_q     <= StFetch;
            end
          end
        end
        StHold: begin
          if (!freeze) begin
            instruction <= buf_q;
            PC          <= buf_pc_q;
            inst_valid  <= 1'b1;
            state_q     <= StFetch;
          end
        end
        StDiscard: begin
          if (imem_valid) state_q <= StFetch;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: latency-programmable memory model feeding a scoreboard, a table of
// straight-line fetch runs, and hand sequences for freeze, redirect, wrap and reset.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_addr = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] instruction;
  logic [31:0] PC;
  logic        inst_valid;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RPC), .NOP_INST(NOP)) dut (
    .clk        (clk),
    .rst        (rst),
    .freeze     (freeze),
    .br_taken   (br_taken),
    .br_addr    (br_addr),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .instruction(instruction),
    .PC         (PC),
    .inst_valid (inst_valid)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    int          lat;
    logic [31:0] target;
    int          nfetch;
    logic [31:0] exp_pc;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2001_0005;
      32'h0000_0020: return 32'hAC22_0010;
      default:       return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endcase
  endfunction

  // Memory model: one request at a time, response 'lat' cycles later.
  int          lat = 1;
  int          req_cnt;
  int          cnt;
  logic        pend;
  logic [31:0] paddr;
  logic [31:0] base = RPC;
  int          snap = 0;

  function automatic logic [31:0] exp_addr();
    return base + 32'(4 * (req_cnt - snap));
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      imem_valid <= 1'b0;
      imem_rdata <= 32'h0;
      pend       <= 1'b0;
      cnt        <= 0;
      req_cnt    <= 0;
      paddr      <= 32'h0;
    end else begin
      imem_valid <= 1'b0;
      if (pend) begin
        if (cnt <= 1) begin
          imem_valid <= 1'b1;
          imem_rdata <= mem_word(paddr);
          pend       <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
      if (imem_req) begin
        chk("imem_addr", imem_addr, exp_addr());
        chk("one_outstanding", 32'(pend), 32'h0);
        sb.push_back('{mem_word(exp_addr()), exp_addr() + 32'd4});
        req_cnt <= req_cnt + 1;
        if (lat <= 1) begin
          imem_valid <= 1'b1;
          imem_rdata <= mem_word(exp_addr());
        end else begin
          pend  <= 1'b1;
          cnt   <= lat - 1;
          paddr <= exp_addr();
        end
      end
    end
  end

  // Output checker: every cycle the IF/ID outputs must be a new word, a held word or a bubble.
  logic        frz_last;
  int          out_cnt = 0;
  logic [31:0] last_inst = NOP;
  logic [31:0] last_pc = 32'h0;
  exp_t        e;

  always @(posedge clk or negedge rst) begin
    if (!rst) frz_last <= 1'b0;
    else      frz_last <= freeze;
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_inst", instruction, NOP);
      chk("rst_pc", PC, 32'h0);
      chk("rst_valid", 32'(inst_valid), 32'h0);
      chk("rst_req", 32'(imem_req), 32'h0);
      last_inst = NOP;
      last_pc   = 32'h0;
    end else if (inst_valid && !frz_last) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h pc %h expected no output", instruction, PC);
      end else begin
        e = sb.pop_front();
        chk("out_inst", instruction, e.inst);
        chk("out_pc", PC, e.pc);
        last_inst = e.inst;
        last_pc   = e.pc;
      end
      out_cnt++;
    end else if (inst_valid) begin
      chk("held_inst", instruction, last_inst);
      chk("held_pc", PC, last_pc);
    end else begin
      chk("bubble_inst", instruction, NOP);
      chk("bubble_pc", PC, last_pc);
    end
  end

  task automatic wait_outs(input int n, input string name);
    int start;
    int k;
    start = out_cnt;
    k = 0;
    while (out_cnt - start < n && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (out_cnt - start < n) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout got %0d outputs expected %0d", name, out_cnt - start, n);
    end
  endtask

  task automatic wait_req(input string name);
    int start;
    int k;
    start = req_cnt;
    k = 0;
    while (req_cnt == start && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (req_cnt == start) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout got no request expected one", name);
    end
  endtask

  task automatic redirect(input logic [31:0] tgt, input logic frz);
    @(negedge clk);
    br_taken = 1'b1;
    br_addr  = tgt;
    freeze   = frz;
    @(posedge clk);
    #1;
    br_taken = 1'b0;
    freeze   = 1'b0;
    sb.delete();
    base = tgt;
    snap = req_cnt;
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{3, 32'h0000_0000, 3, 32'h0000_000C};
    vecs[1] = '{1, 32'h0000_1000, 4, 32'h0000_1010};
    vecs[2] = '{2, 32'h8000_0000, 2, 32'h8000_0008};
    vecs[3] = '{4, 32'hFFFF_FFF8, 3, 32'h0000_0004};

    // Reset release with 1-cycle memory.
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t1_req", 32'(imem_req), 32'h1);
    chk("t1_addr", imem_addr, 32'h0);
    wait_outs(1, "t1_outs");
    chk("t1_inst", instruction, 32'h2001_0005);
    chk("t1_pc", PC, 32'h4);
    chk("t1_valid", 32'(inst_valid), 32'h1);
    chk("t1_next_addr", imem_addr, 32'h4);

    // Straight-line runs at various latencies, including a PC wrap.
    for (int i = 0; i < 4; i++) begin
      lat = vecs[i].lat;
      redirect(vecs[i].target, 1'b0);
      wait_outs(vecs[i].nfetch, "table_outs");
      chk("table_pc", PC, vecs[i].exp_pc);
      chk("table_valid", 32'(inst_valid), 32'h1);
      chk("table_reqs", 32'(req_cnt - snap), 32'(vecs[i].nfetch));
    end

    // Freeze while the response arrives in WAIT.
    lat = 3;
    redirect(32'h20, 1'b0);
    wait_req("t3_req");
    @(negedge clk);
    freeze = 1'b1;
    repeat (6) @(negedge clk);
    chk("t3_hold_valid", 32'(inst_valid), 32'h0);
    freeze = 1'b0;
    wait_outs(1, "t3_outs");
    chk("t3_inst", instruction, 32'hAC22_0010);
    chk("t3_pc", PC, 32'h24);
    chk("t3_next_req", 32'(imem_req), 32'h1);
    chk("t3_next_addr", imem_addr, 32'h24);

    // Redirect while waiting on address 8; the late response must be dropped.
    lat = 3;
    redirect(32'h0, 1'b0);
    wait_outs(2, "t4_pre");
    wait_req("t4_req8");
    redirect(32'h40, 1'b0);
    chk("t4_flush_valid", 32'(inst_valid), 32'h0);
    chk("t4_discard_req", 32'(imem_req), 32'h0);
    wait_outs(1, "t4_outs");
    chk("t4_inst", instruction, mem_word(32'h40));
    chk("t4_pc", PC, 32'h44);

    // Redirect with freeze held while a word sits in the buffer.
    lat = 1;
    redirect(32'h100, 1'b0);
    wait_req("t5_req");
    @(negedge clk);
    freeze = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_hold_valid", 32'(inst_valid), 32'h0);
    redirect(32'h200, 1'b1);
    chk("t5_flush_valid", 32'(inst_valid), 32'h0);
    wait_outs(1, "t5_outs");
    chk("t5_inst", instruction, mem_word(32'h200));
    chk("t5_pc", PC, 32'h204);

    // PC wrap, then asynchronous reset in the middle of a fetch.
    lat = 1;
    redirect(32'hFFFF_FFFC, 1'b0);
    wait_outs(1, "t6_outs");
    chk("t6_wrap_pc", PC, 32'h0);
    chk("t6_wrap_addr", imem_addr, 32'h0);
    lat = 3;
    wait_req("t6_req");
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_inst", instruction, NOP);
    chk("t6_rst_pc", PC, 32'h0);
    chk("t6_rst_valid", 32'(inst_valid), 32'h0);
    chk("t6_rst_req", 32'(imem_req), 32'h0);
    sb.delete();
    base = RPC;
    snap = 0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_restart_addr", imem_addr, RPC);
    wait_outs(1, "t6_restart");
    chk("t6_restart_inst", instruction, 32'h2001_0005);
    chk("t6_restart_pc", PC, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
